// File: rtl/rvi_bj_pkg.sv
// Shared types for the Rvi branch/jump execute stage.
//   bj_op_e    : branch/jump op codes carried on iOp
//   bj_state_e : redirect handshake FSM states
//   bj_res_t   : combinational resolve result, sized for the widest datapath
package rvi_bj_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_JAL  = 3'd1,
    OP_JALR = 3'd2,
    OP_BEQ  = 3'd3,
    OP_BNE  = 3'd4,
    OP_BLT  = 3'd5,
    OP_BGE  = 3'd6
  } bj_op_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_RDR_WAIT = 1'b1
  } bj_state_e;

  // Narrower datapaths use the low bits of tgt/link.
  typedef struct packed {
    logic                taken;
    logic [XLEN_MAX-1:0] tgt;
    logic [XLEN_MAX-1:0] link;
    logic                mispred;
  } bj_res_t;

endpackage

// File: rtl/rvi_bj_resolve.sv
// Combinational branch/jump resolution: target, direction, link PC and
// mispredict versus the front-end prediction.
// Ports: op_i/uns_i select the operation; pc_i, s1_i, s2_i, off_i operands;
//        rvc_i selects a 2-byte link step; pred_taken_i/pred_tgt_i are the
//        prediction; res_o carries the resolved result.
module rvi_bj_resolve
  import rvi_bj_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [2:0]   op_i,
  input  logic         uns_i,
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] s1_i,
  input  logic [W-1:0] s2_i,
  input  logic [W-1:0] off_i,
  input  logic         rvc_i,
  input  logic         pred_taken_i,
  input  logic [W-1:0] pred_tgt_i,
  output bj_res_t      res_o
);

  logic [W-1:0] pc_sum;
  logic [W-1:0] jr_sum;
  logic [W-1:0] tgt;
  logic [W-1:0] link;
  logic [W:0]   a_ext;
  logic [W:0]   b_ext;
  logic         less;
  logic         taken;
  logic         is_bj;
  logic         mispred;

  assign pc_sum = pc_i + off_i;
  assign jr_sum = s1_i + off_i;
  assign tgt    = (op_i == OP_JALR) ? {jr_sum[W-1:1], 1'b0} : pc_sum;
  assign link   = pc_i + (rvc_i ? W'(2) : W'(4));

  // One extra bit lets a single signed compare cover both signed and unsigned.
  assign a_ext = {(uns_i ? 1'b0 : s1_i[W-1]), s1_i};
  assign b_ext = {(uns_i ? 1'b0 : s2_i[W-1]), s2_i};
  assign less  = $signed(a_ext) < $signed(b_ext);

  // Direction; unused encodings behave like NONE.
  always_comb begin
    taken = 1'b0;
    is_bj = 1'b1;
    case (op_i)
      OP_JAL, OP_JALR: taken = 1'b1;
      OP_BEQ:          taken = (s1_i == s2_i);
      OP_BNE:          taken = (s1_i != s2_i);
      OP_BLT:          taken = less;
      OP_BGE:          taken = !less;
      default:         is_bj = 1'b0;
    endcase
  end

  assign mispred = is_bj && ((taken != pred_taken_i) || (taken && (tgt != pred_tgt_i)));

  assign res_o = '{taken:   taken,
                   tgt:     XLEN_MAX'(tgt),
                   link:    XLEN_MAX'(link),
                   mispred: mispred};

endmodule

// File: rtl/rvi_bj_ex_pipe.sv
// Registered branch/jump execute stage with held redirect request.
// Config macro: ZION_RVI_BJ_RVC_EN adds iRvc (2-byte link step) and removes
//   the misalignment check and oMisalign.
// Ports: iVld/iRdy input handshake with op/operands/prediction/tag;
//        oVld/oRdy result handshake with oTaken, oLinkPc, oTag (oMisalign);
//        oRdrVld/oRdrPc/iRdrAck redirect handshake; oMisCnt saturating
//        mispredict count. clk, synchronous active-high rst.
module rvi_bj_ex_pipe
  import rvi_bj_pkg::*;
#(
  parameter int unsigned RV64      = 0,
  parameter int unsigned CPU_WIDTH = 32 * (RV64 + 1),
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iVld,
  output logic                 iRdy,
  input  logic [2:0]           iOp,
  input  logic                 iUnsigned,
  input  logic [CPU_WIDTH-1:0] iPc,
  input  logic [CPU_WIDTH-1:0] iS1,
  input  logic [CPU_WIDTH-1:0] iS2,
  input  logic [CPU_WIDTH-1:0] iOffset,
`ifdef ZION_RVI_BJ_RVC_EN
  input  logic                 iRvc,
`endif
  input  logic                 iPredTaken,
  input  logic [CPU_WIDTH-1:0] iPredTgt,
  input  logic [TAG_W-1:0]     iTag,
  output logic                 oVld,
  input  logic                 oRdy,
  output logic                 oTaken,
  output logic [CPU_WIDTH-1:0] oLinkPc,
  output logic [TAG_W-1:0]     oTag,
`ifndef ZION_RVI_BJ_RVC_EN
  output logic                 oMisalign,
`endif
  output logic                 oRdrVld,
  output logic [CPU_WIDTH-1:0] oRdrPc,
  input  logic                 iRdrAck,
  output logic [CNT_W-1:0]     oMisCnt
);

  bj_res_t              res;
  logic                 rvc;
  logic [CPU_WIDTH-1:0] res_tgt;
  logic [CPU_WIDTH-1:0] res_link;
  logic                 misalign_c;
  logic                 redirect_c;
  logic                 accept;
  logic                 unused_res;

  bj_state_e            state_q, state_d;
  logic                 vld_q, vld_d;
  logic                 taken_q, taken_d;
  logic [CPU_WIDTH-1:0] link_q, link_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 rdr_vld_q, rdr_vld_d;
  logic [CPU_WIDTH-1:0] rdr_pc_q, rdr_pc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`ifndef ZION_RVI_BJ_RVC_EN
  logic                 misalign_q, misalign_d;
`endif

`ifdef ZION_RVI_BJ_RVC_EN
  assign rvc        = iRvc;
  assign misalign_c = 1'b0;
`else
  assign rvc        = 1'b0;
  assign misalign_c = res.taken && res_tgt[1];
`endif

  rvi_bj_resolve #(.W(CPU_WIDTH)) u_resolve (
    .op_i         (iOp),
    .uns_i        (iUnsigned),
    .pc_i         (iPc),
    .s1_i         (iS1),
    .s2_i         (iS2),
    .off_i        (iOffset),
    .rvc_i        (rvc),
    .pred_taken_i (iPredTaken),
    .pred_tgt_i   (iPredTgt),
    .res_o        (res)
  );

  assign res_tgt    = res.tgt[CPU_WIDTH-1:0];
  assign res_link   = res.link[CPU_WIDTH-1:0];
  // Upper bits are don't-care on RV32.
  assign unused_res = ^{res.tgt, res.link};

  assign iRdy       = (state_q == ST_RUN) && (!vld_q || oRdy);
  assign accept     = iVld && iRdy;
  // A misaligned taken op traps downstream instead of redirecting.
  assign redirect_c = res.mispred && !misalign_c;

  // Next-state: output register, redirect FSM and counter.
  always_comb begin
    state_d   = state_q;
    vld_d     = vld_q;
    taken_d   = taken_q;
    link_d    = link_q;
    tag_d     = tag_q;
    rdr_vld_d = rdr_vld_q;
    rdr_pc_d  = rdr_pc_q;
    cnt_d     = cnt_q;
`ifndef ZION_RVI_BJ_RVC_EN
    misalign_d = misalign_q;
`endif

    if (oRdy) vld_d = 1'b0;
    if (accept) begin
      vld_d   = 1'b1;
      taken_d = res.taken;
      link_d  = res_link;
      tag_d   = iTag;
`ifndef ZION_RVI_BJ_RVC_EN
      misalign_d = misalign_c;
`endif
    end

    case (state_q)
      ST_RUN: begin
        if (accept && redirect_c) begin
          state_d   = ST_RDR_WAIT;
          rdr_vld_d = 1'b1;
          rdr_pc_d  = res.taken ? res_tgt : res_link;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RDR_WAIT: begin
        if (iRdrAck) begin
          state_d   = ST_RUN;
          rdr_vld_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 1'b0;
      taken_q   <= 1'b0;
      link_q    <= '0;
      tag_q     <= '0;
      rdr_vld_q <= 1'b0;
      rdr_pc_q  <= '0;
      cnt_q     <= '0;
`ifndef ZION_RVI_BJ_RVC_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      vld_q     <= vld_d;
      taken_q   <= taken_d;
      link_q    <= link_d;
      tag_q     <= tag_d;
      rdr_vld_q <= rdr_vld_d;
      rdr_pc_q  <= rdr_pc_d;
      cnt_q     <= cnt_d;
`ifndef ZION_RVI_BJ_RVC_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign oVld    = vld_q;
  assign oTaken  = taken_q;
  assign oLinkPc = link_q;
  assign oTag    = tag_q;
  assign oRdrVld = rdr_vld_q;
  assign oRdrPc  = rdr_pc_q;
  assign oMisCnt = cnt_q;
`ifndef ZION_RVI_BJ_RVC_EN
  assign oMisalign = misalign_q;
`endif

endmodule

// File: tb/tb_rvi_bj_ex_pipe.sv
// Scoreboard bench for rvi_bj_ex_pipe: directed cases then random ops,
// checked against a behavioural model. Counter width is shrunk so that
// saturation is reachable.
module tb_rvi_bj_ex_pipe;
  import rvi_bj_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 4;
  localparam int unsigned CW = 3;

  typedef struct {
    logic [2:0]    op;
    logic          uns;
    logic [W-1:0]  pc, s1, s2, off;
    logic          rvc;
    logic          pt;
    logic [W-1:0]  ptgt;
    logic [TW-1:0] tag;
  } stim_t;

  typedef struct {
    logic          taken;
    logic [W-1:0]  link;
    logic [TW-1:0] tag;
    logic          mal;
  } exp_out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          iVld = 1'b0;
  logic          iRdy;
  logic [2:0]    iOp = 3'd0;
  logic          iUnsigned = 1'b0;
  logic [W-1:0]  iPc = '0, iS1 = '0, iS2 = '0, iOffset = '0;
`ifdef ZION_RVI_BJ_RVC_EN
  logic          iRvc = 1'b0;
`endif
  logic          iPredTaken = 1'b0;
  logic [W-1:0]  iPredTgt = '0;
  logic [TW-1:0] iTag = '0;
  logic          oVld;
  logic          oRdy = 1'b1;
  logic          oTaken;
  logic [W-1:0]  oLinkPc;
  logic [TW-1:0] oTag;
`ifndef ZION_RVI_BJ_RVC_EN
  logic          oMisalign;
`endif
  logic          oRdrVld;
  logic [W-1:0]  oRdrPc;
  logic          iRdrAck = 1'b0;
  logic [CW-1:0] oMisCnt;

  rvi_bj_ex_pipe #(.RV64(0), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .iVld       (iVld),
    .iRdy       (iRdy),
    .iOp        (iOp),
    .iUnsigned  (iUnsigned),
    .iPc        (iPc),
    .iS1        (iS1),
    .iS2        (iS2),
    .iOffset    (iOffset),
`ifdef ZION_RVI_BJ_RVC_EN
    .iRvc       (iRvc),
`endif
    .iPredTaken (iPredTaken),
    .iPredTgt   (iPredTgt),
    .iTag       (iTag),
    .oVld       (oVld),
    .oRdy       (oRdy),
    .oTaken     (oTaken),
    .oLinkPc    (oLinkPc),
    .oTag       (oTag),
`ifndef ZION_RVI_BJ_RVC_EN
    .oMisalign  (oMisalign),
`endif
    .oRdrVld    (oRdrVld),
    .oRdrPc     (oRdrPc),
    .iRdrAck    (iRdrAck),
    .oMisCnt    (oMisCnt)
  );

  int checks = 0;
  int fails  = 0;

  exp_out_t     oq[$];
  logic [W-1:0] rq[$];

  bit mon_en   = 1'b0;
  bit rnd_en   = 1'b0;
  bit ordy_dir = 1'b1;
  bit ack_dir  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: architectural meaning of each op, expressed directly.
  function automatic void model(input stim_t s, output logic taken, output logic [W-1:0] tgt,
                                output logic [W-1:0] link, output logic mal,
                                output logic rdr, output logic [W-1:0] rpc);
    logic lt;
    logic is_bj;
    if (s.op == OP_JALR) tgt = (s.s1 + s.off) & ~W'(1);
    else                 tgt = s.pc + s.off;
    if (s.uns) lt = s.s1 < s.s2;
    else       lt = $signed(s.s1) < $signed(s.s2);
    is_bj = 1'b1;
    case (s.op)
      OP_JAL, OP_JALR: taken = 1'b1;
      OP_BEQ:          taken = (s.s1 == s.s2);
      OP_BNE:          taken = (s.s1 != s.s2);
      OP_BLT:          taken = lt;
      OP_BGE:          taken = !lt;
      default: begin taken = 1'b0; is_bj = 1'b0; end
    endcase
`ifdef ZION_RVI_BJ_RVC_EN
    link = s.pc + (s.rvc ? W'(2) : W'(4));
    mal  = 1'b0;
`else
    link = s.pc + W'(4);
    mal  = taken && tgt[1];
`endif
    rdr = is_bj && !mal && ((taken != s.pt) || (taken && tgt != s.ptgt));
    rpc = taken ? tgt : link;
  endfunction

  function automatic stim_t mk(input logic [2:0] op, input logic uns, input logic [W-1:0] pc,
                               input logic [W-1:0] s1, input logic [W-1:0] s2,
                               input logic [W-1:0] off, input logic rvc, input logic pt,
                               input logic [W-1:0] ptgt, input logic [TW-1:0] tag);
    stim_t s;
    s.op = op; s.uns = uns; s.pc = pc; s.s1 = s1; s.s2 = s2; s.off = off;
    s.rvc = rvc; s.pt = pt; s.ptgt = ptgt; s.tag = tag;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    iVld = 1'b1; iOp = s.op; iUnsigned = s.uns; iPc = s.pc; iS1 = s.s1; iS2 = s.s2;
    iOffset = s.off; iPredTaken = s.pt; iPredTgt = s.ptgt; iTag = s.tag;
`ifdef ZION_RVI_BJ_RVC_EN
    iRvc = s.rvc;
`endif
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input stim_t s);
    exp_out_t e;
    logic tk, mal, rdr;
    logic [W-1:0] tg, lk, rp;
    bit done;
    done = 1'b0;
    model(s, tk, tg, lk, mal, rdr, rp);
    drive(s);
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (iRdy) begin
        e.taken = tk; e.link = lk; e.tag = s.tag; e.mal = mal;
        oq.push_back(e);
        if (rdr) rq.push_back(rp);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL issue_timeout op=%0d tag=%0h", s.op, s.tag);
    end
    iVld = 1'b0;
  endtask

  // Downstream ready and redirect ack: random or directed.
  always @(posedge clk) begin
    #2;
    oRdy    = rnd_en ? ($urandom_range(0, 3) != 0) : ordy_dir;
    iRdrAck = rnd_en ? ($urandom_range(0, 2) == 0) : ack_dir;
  end

  // Monitor: pops expectations whenever the DUT presents a result or redirect.
  exp_out_t     h;
  bit           hold_v = 1'b0;
  bit           rdr_prev = 1'b0;
  logic [W-1:0] rdr_pc_h = '0;
  logic [CW-1:0] exp_cnt = '0;

  always @(negedge clk) begin
    exp_out_t e;
    logic [W-1:0] rp;
    if (!mon_en) begin
      oq.delete(); rq.delete();
      exp_cnt = '0; hold_v = 1'b0; rdr_prev = 1'b0;
    end else begin
      if (oVld) begin
        if (hold_v) begin
          chk("hold_taken", oTaken, h.taken);
          chk("hold_link", oLinkPc, h.link);
          chk("hold_tag", oTag, h.tag);
        end
        if (oRdy) begin
          if (oq.size() == 0) begin
            checks++; fails++;
            $display("FAIL out_unexpected act_tag=%0h exp=none", oTag);
          end else begin
            e = oq.pop_front();
            chk("out_taken", oTaken, e.taken);
            chk("out_link", oLinkPc, e.link);
            chk("out_tag", oTag, e.tag);
`ifndef ZION_RVI_BJ_RVC_EN
            chk("out_misalign", oMisalign, e.mal);
`endif
          end
          hold_v = 1'b0;
        end else begin
          h.taken = oTaken; h.link = oLinkPc; h.tag = oTag; h.mal = 1'b0;
          hold_v = 1'b1;
        end
      end else begin
        hold_v = 1'b0;
      end
      if (oRdrVld) begin
        if (!rdr_prev) begin
          exp_cnt = (exp_cnt == {CW{1'b1}}) ? exp_cnt : exp_cnt + CW'(1);
          if (rq.size() == 0) begin
            checks++; fails++;
            $display("FAIL rdr_unexpected act_pc=%0h exp=none", oRdrPc);
          end else begin
            rp = rq.pop_front();
            chk("rdr_pc", oRdrPc, rp);
          end
        end else begin
          chk("rdr_hold_pc", oRdrPc, rdr_pc_h);
        end
        rdr_pc_h = oRdrPc;
        chk("rdr_stall_irdy", iRdy, 1'b0);
      end
      rdr_prev = oRdrVld && !iRdrAck;
      chk("mis_cnt", oMisCnt, exp_cnt);
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ovld"}, oVld, 1'b0);
    chk({pfx, "_rdrvld"}, oRdrVld, 1'b0);
    chk({pfx, "_taken"}, oTaken, 1'b0);
    chk({pfx, "_link"}, oLinkPc, '0);
    chk({pfx, "_rdrpc"}, oRdrPc, '0);
    chk({pfx, "_tag"}, oTag, '0);
    chk({pfx, "_cnt"}, oMisCnt, '0);
    chk({pfx, "_irdy"}, iRdy, 1'b1);
`ifndef ZION_RVI_BJ_RVC_EN
    chk({pfx, "_mal"}, oMisalign, 1'b0);
`endif
  endtask

  initial begin
    stim_t s;
    logic tk, mal, rdr;
    logic [W-1:0] tg, lk, rp;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Correctly predicted taken BEQ.
    issue(mk(OP_BEQ, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b1, 32'h120, 4'h1));
    @(negedge clk);
    chk("beq_irdy", iRdy, 1'b1);
    chk("beq_rdrvld", oRdrVld, 1'b0);
    chk("beq_link", oLinkPc, 32'h104);
    @(posedge clk); #1;

    // Signed BLT mispredicted not-taken; redirect held for three cycles.
    issue(mk(OP_BLT, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b0, 32'h0, 4'h2));
    repeat (3) begin
      @(negedge clk);
      chk("blt_rdr_held", oRdrVld, 1'b1);
      chk("blt_rdr_pc", oRdrPc, 32'h240);
      chk("blt_irdy_stall", iRdy, 1'b0);
    end
    @(posedge clk); #1 ack_dir = 1'b1;
    @(posedge clk); #1 ack_dir = 1'b0;
    @(negedge clk);
    chk("ack_irdy", iRdy, 1'b1);
    chk("ack_rdr_drop", oRdrVld, 1'b0);
    chk("ack_cnt", oMisCnt, 3'd1);
    @(posedge clk); #1;

    // Same operands unsigned: not taken, no redirect.
    issue(mk(OP_BLT, 1'b1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b0, 32'h0, 4'h3));
    @(negedge clk);
    chk("bltu_taken", oTaken, 1'b0);
    chk("bltu_rdrvld", oRdrVld, 1'b0);
    @(posedge clk); #1;

    // JALR clears bit 0 of the target.
    issue(mk(OP_JALR, 1'b0, 32'h300, 32'h2001, 32'h0, 32'h4, 1'b1, 1'b1, 32'h2004, 4'h4));
    @(negedge clk);
    chk("jalr_taken", oTaken, 1'b1);
    chk("jalr_rdrvld", oRdrVld, 1'b0);
`ifdef ZION_RVI_BJ_RVC_EN
    chk("jalr_link", oLinkPc, 32'h302);
`else
    chk("jalr_link", oLinkPc, 32'h304);
`endif
    @(posedge clk); #1;

`ifndef ZION_RVI_BJ_RVC_EN
    // Misaligned taken JAL: no redirect, counter unchanged.
    issue(mk(OP_JAL, 1'b0, 32'h0, 32'h0, 32'h0, 32'h6, 1'b0, 1'b0, 32'h0, 4'h5));
    @(negedge clk);
    chk("mal_flag", oMisalign, 1'b1);
    chk("mal_rdrvld", oRdrVld, 1'b0);
    chk("mal_cnt", oMisCnt, 3'd1);
    @(posedge clk); #1;
`endif

    // Output stall: result held while downstream is not ready.
    ordy_dir = 1'b0;
    issue(mk(OP_BNE, 1'b0, 32'h400, 32'd9, 32'd9, 32'h10, 1'b0, 1'b0, 32'h0, 4'h6));
    s = mk(OP_BNE, 1'b0, 32'h500, 32'd1, 32'd9, 32'h10, 1'b0, 1'b1, 32'h510, 4'h7);
    drive(s);
    repeat (4) begin
      @(negedge clk);
      chk("stall_irdy", iRdy, 1'b0);
      chk("stall_ovld", oVld, 1'b1);
      chk("stall_tag", oTag, 4'h6);
    end
    @(posedge clk); #1 ordy_dir = 1'b1;
    issue(s);

    // Reset while a redirect is pending.
    issue(mk(OP_JAL, 1'b0, 32'h40, 32'h0, 32'h0, 32'h10, 1'b0, 1'b0, 32'h0, 4'h8));
    @(negedge clk);
    chk("pre_rst_rdr", oRdrVld, 1'b1);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Randomised traffic with random back-pressure and ack timing.
    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s.op  = 3'($urandom_range(0, 6));
      s.uns = 1'($urandom_range(0, 1));
      s.pc  = W'($urandom) & ~W'(3);
      s.s1  = W'($urandom);
      case ($urandom_range(0, 3))
        0: s.s2 = s.s1;
        1: s.s2 = W'($urandom_range(0, 7));
        2: s.s2 = 32'h8000_0000;
        default: s.s2 = W'($urandom);
      endcase
      s.off  = (W'($urandom_range(0, 8191)) - W'(4096)) & ~W'(1);
      s.rvc  = 1'($urandom_range(0, 1));
      s.pt   = 1'($urandom_range(0, 1));
      s.ptgt = '0;
      s.tag  = TW'(i);
      model(s, tk, tg, lk, mal, rdr, rp);
      s.ptgt = ($urandom_range(0, 1) != 0) ? tg : W'($urandom);
      issue(s);
    end

    // Counter saturation.
    rnd_en = 1'b0; ordy_dir = 1'b1; ack_dir = 1'b1;
    for (int i = 0; i < 9; i++)
      issue(mk(OP_JAL, 1'b0, W'(i * 16), 32'h0, 32'h0, 32'h8, 1'b0, 1'b0, 32'h0, TW'(i)));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", oMisCnt, 3'd7);
    chk("drain_out", 64'(oq.size()), 64'd0);
    chk("drain_rdr", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
